addsub_arbiter: RTL and testbench
=================================

// Module: addsub_arbiter
// PURPOSE
//  Shares one addsub datapath (N-bit signed operands a/b/c, SM/SD/AS controls, N+1-bit Sum/Sub)
//  between NREQ requesters. Grants one request at a time, round-robin. Holds the operands and
//  controls stable for HOLD cycles, then captures the selected result and returns it tagged with
//  the requester id. Non-pipelined: exactly one operation is in flight.
// PARAMETERS
//  N     4  operand width (datapath outputs are N+1 bits)
//  NREQ  4  number of requesters, >=2
//  HOLD  5  cycles dp_* are held stable before capture, >=1 (covers datapath register depth)
//  ID_W  2  requester id width, = $clog2(NREQ)
// PORTS
//  clk       in   1         clock, rising edge
//  rst_n     in   1         asynchronous active-low reset
//  en        in   1         enables new grants; an in-flight op always completes
//  req       in   NREQ      per-requester request, held until granted
//  req_op    in   NREQ      per-requester op: 0 add, 1 sub
//  req_sel   in   NREQ      per-requester 2nd operand: 0 b, 1 c
//  req_a     in   NREQ*N    operand a, requester i at [i*N +: N]
//  req_b     in   NREQ*N    operand b, same packing
//  req_c     in   NREQ*N    operand c, same packing
//  gnt       out  NREQ      one-hot grant, 1-cycle pulse; operands are taken that cycle
//  dp_a/dp_b/dp_c out N     registered operands to datapath
//  dp_sm     out  1         registered = req_sel of winner
//  dp_as     out  1         registered = req_op of winner
//  dp_sd     out  1         registered = req_op of winner (sub results go to Sub)
//  dp_sum    in   N+1       datapath Sum
//  dp_sub    in   N+1       datapath Sub
//  rsp_valid out  1         1-cycle result strobe, no backpressure
//  rsp_id    out  ID_W      winner index of the result
//  rsp_data  out  N+1       signed result
//  idle      out  1         state==IDLE and no response pending
// BEHAVIOUR
//  Reset: all registered outputs 0, state IDLE, rr_ptr=NREQ-1 (req[0] wins first), idle=1.
//  FSM IDLE -> BUSY -> CAPT -> IDLE.
//  IDLE: if en and |req: gnt (combinational) = first set req scanning rr_ptr+1 upward, with
//   wraparound. Edge latches the winner's a/b/c/op/sel into dp_*, sets cnt=HOLD-1 and win_id,
//   and moves to BUSY. Otherwise gnt=0.
//  BUSY: dp_* held constant; cnt decrements. Moves to CAPT when cnt==0 (HOLD cycles in BUSY).
//  CAPT: at the edge, rsp_data <= dp_sd ? dp_sub : dp_sum, rsp_id <= win_id, rsp_valid <= 1,
//   rr_ptr <= win_id. Moves to IDLE.
//  Timing: gnt in cycle t -> dp_* valid t+1..t+HOLD+1 -> rsp_valid in cycle t+HOLD+2 only.
//   A new gnt is possible in cycle t+HOLD+2 (issue period HOLD+2).
//  Arithmetic: no width change in the arbiter; rsp_data is the datapath's N+1-bit result verbatim.
//  en low in BUSY/CAPT: op completes, response is delivered, and no new gnt is issued.
//  req dropped after grant: no effect on the in-flight op. gnt is never asserted outside IDLE.
//  Async reset mid-op: op is discarded, no rsp_valid, rr_ptr returns to NREQ-1.
// CONFIGURATION
//  ADDSUB_ARB_STATS_EN defined: adds output stat_cnt [NREQ*8], one 8-bit saturating grant counter
//   per requester (cleared by rst_n, increments on gnt[i], holds at 255).
//  Not defined: stat_cnt port and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package addsub_arb_pkg: state enum (IDLE, BUSY, CAPT), STAT_W=8, id-width function.
//  Sub-module addsub_rr_pick: combinational round-robin pick (req, rr_ptr -> gnt one-hot, win_id, any).
// TESTING (N=4, NREQ=4, HOLD=5)
//  1 req[0] add, sel=0, a=3, b=2 at t -> gnt=0001 at t; rsp_valid only at t+7; rsp_data=5; rsp_id=0.
//  2 req[2] sub, sel=1, a=-8, c=7 -> dp_sm=1, dp_sd=1; rsp_data=-15 (5'b10001); rsp_id=2.
//  3 all req held high -> grants 0,1,2,3,0 spaced 7 cycles; each rsp_id matches its grant.
//  4 en drops in BUSY -> that rsp is still delivered; no further gnt; idle=1 afterwards.
//  5 rst_n low during BUSY -> outputs 0 immediately; no rsp after release; next grant goes to req[0].
//  6 STATS_EN, req[1] only, 300 ops -> stat_cnt[15:8]=255; other counters 0.

Source files
------------

// File: rtl/addsub_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_arb_pkg
// Description : Shared types and helpers for the add/sub datapath arbiter.
// Revision    : 1.0
// ============================================================================
package addsub_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_CAPT = 2'd2
    } state_e;

    localparam int STAT_W = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : addsub_rr_pick
// Description : Combinational round-robin pick; scans upward from rr_ptr+1.
// Revision    : 1.0
// ============================================================================
module addsub_rr_pick
    import addsub_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] win_id,
    output logic            any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt    = '0;
        win_id = '0;
        any    = 1'b0;
        idx    = '0;
        // k runs to NREQ so the previous winner is considered last
        for (int k = 1; k <= NREQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                win_id   = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : addsub_arbiter
// Description : Round-robin sharing of one addsub datapath between NREQ
//               requesters. Optional ADDSUB_ARB_STATS_EN adds grant counters.
// Revision    : 1.0
// ============================================================================
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int NREQ = 4,
    parameter int HOLD = 5,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ-1:0]      req_sel,
    input  logic [NREQ*N-1:0]    req_a,
    input  logic [NREQ*N-1:0]    req_b,
    input  logic [NREQ*N-1:0]    req_c,
    output logic [NREQ-1:0]      gnt,
    output logic [N-1:0]         dp_a,
    output logic [N-1:0]         dp_b,
    output logic [N-1:0]         dp_c,
    output logic                 dp_sm,
    output logic                 dp_as,
    output logic                 dp_sd,
    input  logic [N:0]           dp_sum,
    input  logic [N:0]           dp_sub,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [N:0]           rsp_data,
    output logic                 idle
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_cnt
`endif
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] win_id_q, win_id_d;
    logic [N-1:0]    dp_a_q, dp_a_d;
    logic [N-1:0]    dp_b_q, dp_b_d;
    logic [N-1:0]    dp_c_q, dp_c_d;
    logic            dp_sm_q, dp_sm_d;
    logic            dp_op_q, dp_op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [N:0]      rsp_data_q, rsp_data_d;

    logic [NREQ-1:0] pick_gnt;
    logic [ID_W-1:0] pick_id;
    logic            pick_any;

    addsub_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .win_id (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        win_id_d    = win_id_q;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        dp_c_d      = dp_c_q;
        dp_sm_d     = dp_sm_q;
        dp_op_d     = dp_op_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        gnt         = '0;
        case (state_q)
            ST_IDLE: begin
                if (en && pick_any) begin
                    gnt      = pick_gnt;
                    dp_a_d   = req_a[int'(pick_id) * N +: N];
                    dp_b_d   = req_b[int'(pick_id) * N +: N];
                    dp_c_d   = req_c[int'(pick_id) * N +: N];
                    dp_sm_d  = req_sel[pick_id];
                    dp_op_d  = req_op[pick_id];
                    win_id_d = pick_id;
                    cnt_d    = CNT_W'(HOLD - 1);
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CAPT: begin
                rsp_data_d  = dp_op_q ? dp_sub : dp_sum;
                rsp_id_d    = win_id_q;
                rsp_valid_d = 1'b1;
                rr_ptr_d    = win_id_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= ID_W'(NREQ - 1);
            win_id_q    <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_c_q      <= '0;
            dp_sm_q     <= 1'b0;
            dp_op_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            win_id_q    <= win_id_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            dp_c_q      <= dp_c_d;
            dp_sm_q     <= dp_sm_d;
            dp_op_q     <= dp_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Add and sub-select share one flop: a sub op both subtracts and routes to Sub.
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_c      = dp_c_q;
    assign dp_sm     = dp_sm_q;
    assign dp_as     = dp_op_q;
    assign dp_sd     = dp_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign idle      = (state_q == ST_IDLE) && !rsp_valid_q;

`ifdef ADDSUB_ARB_STATS_EN
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_stat
            logic [STAT_W-1:0] stat_q, stat_d;

            always_comb begin
                stat_d = stat_q;
                if (gnt[i] && (stat_q != {STAT_W{1'b1}})) begin
                    stat_d = stat_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stat_q <= '0;
                end else begin
                    stat_q <= stat_d;
                end
            end

            assign stat_cnt[i*STAT_W +: STAT_W] = stat_q;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_arbiter
// Description : Scoreboard bench for addsub_arbiter with a 2-stage datapath model.
// Revision    : 1.0
// ============================================================================
module tb_addsub_arbiter;

    localparam int N    = 4;
    localparam int NREQ = 4;
    localparam int HOLD = 5;
    localparam int LAT  = HOLD + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_op;
    logic [NREQ-1:0]   req_sel;
    logic [NREQ*N-1:0] req_a, req_b, req_c;
    logic [NREQ-1:0]   gnt;
    logic [N-1:0]      dp_a, dp_b, dp_c;
    logic              dp_sm, dp_as, dp_sd;
    logic [N:0]        dp_sum, dp_sub;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [N:0]        rsp_data;
    logic              idle;
`ifdef ADDSUB_ARB_STATS_EN
    logic [NREQ*8-1:0] stat_cnt;
`endif

    addsub_arbiter #(.N(N), .NREQ(NREQ), .HOLD(HOLD), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .req_op    (req_op),
        .req_sel   (req_sel),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .gnt       (gnt),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_c      (dp_c),
        .dp_sm     (dp_sm),
        .dp_as     (dp_as),
        .dp_sd     (dp_sd),
        .dp_sum    (dp_sum),
        .dp_sub    (dp_sub),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .idle      (idle)
`ifdef ADDSUB_ARB_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External datapath: two register stages, well inside HOLD
    logic [N:0] p1_sum, p1_sub, p2_sum, p2_sub;
    logic [N:0] ext_a, ext_o;
    assign ext_a = {dp_a[N-1], dp_a};
    assign ext_o = dp_sm ? {dp_c[N-1], dp_c} : {dp_b[N-1], dp_b};
    always @(posedge clk) begin
        p1_sum <= ext_a + ext_o;
        p1_sub <= ext_a - ext_o;
        p2_sum <= p1_sum;
        p2_sub <= p1_sub;
    end
    assign dp_sum = p2_sum;
    assign dp_sub = p2_sub;

    typedef struct {
        int         id;
        logic [N:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got id %0d data %0h with nothing expected (cycle %0d)",
                         rsp_id, rsp_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic set_ops(input int i, input logic op, input logic sel,
                           input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        req_op[i]        = op;
        req_sel[i]       = sel;
        req_a[i*N +: N]  = a;
        req_b[i*N +: N]  = b;
        req_c[i*N +: N]  = c;
    endtask

    // Raises mask, waits for the grant, checks it and queues the expected result.
    // Returns at the negedge following the grant cycle with all requests dropped.
    task automatic issue(input logic [3:0] mask, input int exp_w,
                         input logic [N:0] exp_data, input bit push);
        exp_t e;
        @(negedge clk);
        req = mask;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (gnt != 4'b0) break;
            @(negedge clk);
            #1;
        end
        chk("gnt_onehot", 32'(gnt), 32'(4'b1 << exp_w));
        if (push) begin
            e.id   = exp_w;
            e.data = exp_data;
            e.cyc  = cyc + LAT;
            sb.push_back(e);
        end
        @(negedge clk);
        req = '0;
        #1;
        chk("gnt_pulse", 32'(gnt), 32'd0);
    endtask

    task automatic wait_quiet();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && idle) break;
        end
        chk("drained", sb.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [N:0] exp3 [4];

    initial begin
        int prev;
        int seen;
        rst_n   = 1'b0;
        en      = 1'b1;
        req     = '0;
        req_op  = '0;
        req_sel = '0;
        req_a   = '0;
        req_b   = '0;
        req_c   = '0;
        exp3[0] = 5'd3;
        exp3[1] = 5'd8;
        exp3[2] = 5'b10111;
        exp3[3] = 5'd15;

        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_dp_a", 32'(dp_a), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        rst_n = 1'b1;

        // 1: single add, b operand
        set_ops(0, 1'b0, 1'b0, 4'd3, 4'd2, 4'd6);
        issue(4'b0001, 0, 5'd5, 1'b1);
        chk("busy_not_idle", 32'(idle), 0);
        wait_quiet();

        // 2: sub, c operand, negative result
        set_ops(2, 1'b1, 1'b1, 4'b1000, 4'd1, 4'd7);
        issue(4'b0100, 2, 5'b10001, 1'b1);
        chk("dp_sm", 32'(dp_sm), 1);
        chk("dp_sd", 32'(dp_sd), 1);
        chk("dp_as", 32'(dp_as), 1);
        chk("dp_a", 32'(dp_a), 32'h8);
        chk("dp_c", 32'(dp_c), 32'h7);
        wait_quiet();

        // 3: all requesting -> strict rotation from req[0]
        pulse_reset();
        set_ops(0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0);
        set_ops(1, 1'b1, 1'b0, 4'd5, 4'b1101, 4'd0);
        set_ops(2, 1'b0, 1'b1, 4'b1100, 4'd3, 4'b1011);
        set_ops(3, 1'b1, 1'b1, 4'd7, 4'd1, 4'b1000);
        @(negedge clk);
        req = 4'hF;
        #1;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            exp_t e;
            for (int k = 0; k < 40; k++) begin
                if (gnt != 4'b0) break;
                @(negedge clk);
                #1;
            end
            chk("rr_order", 32'(gnt), 32'(4'b1 << (n % 4)));
            if (n > 0) chk("rr_spacing", cyc - prev, LAT);
            prev   = cyc;
            e.id   = n % 4;
            e.data = exp3[n % 4];
            e.cyc  = cyc + LAT;
            sb.push_back(e);
            @(negedge clk);
            #1;
        end
        req = '0;
        wait_quiet();

        // 4: en dropped while busy
        issue(4'b0010, 1, 5'd8, 1'b1);
        en  = 1'b0;
        req = 4'b1010;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (gnt != 4'b0) seen++;
        end
        chk("no_gnt_en_low", seen, 0);
        chk("idle_after_en_low", 32'(idle), 1);
        chk("en_low_rsp_delivered", sb.size(), 0);
        req = '0;
        en  = 1'b1;

        // 5: async reset mid-op discards the op and rewinds rr_ptr
        issue(4'b0100, 2, 5'd0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dp_a", 32'(dp_a), 0);
        chk("arst_dp_sd", 32'(dp_sd), 0);
        chk("arst_rsp_id", 32'(rsp_id), 0);
        chk("arst_idle", 32'(idle), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        set_ops(0, 1'b0, 1'b0, 4'd2, 4'b1111, 4'd0);
        issue(4'b0101, 0, 5'd1, 1'b1);
        wait_quiet();

`ifdef ADDSUB_ARB_STATS_EN
        // 6: grant counter saturation
        pulse_reset();
        for (int n = 0; n < 300; n++) begin
            issue(4'b0010, 1, 5'd8, 1'b1);
        end
        wait_quiet();
        chk("stat_r1", 32'(stat_cnt[15:8]), 255);
        chk("stat_r0", 32'(stat_cnt[7:0]), 0);
        chk("stat_r2", 32'(stat_cnt[23:16]), 0);
        chk("stat_r3", 32'(stat_cnt[31:24]), 0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
